// File: rtl/tl_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : tl_pkg                                                    |
// | Purpose  : Shared types, phase encodings, light codes and the        |
// |            config legality helper for the traffic phase controller.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package tl_pkg;

   // Seconds value shown on a lane display
   typedef logic [6:0] time_t;

   // Controller phases; encoding is visible on the phase output
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      G1R2 = 3'd1,
      Y1R2 = 3'd2,
      R1G2 = 3'd3,
      R1Y2 = 3'd4
   } phase_e;

   // One-hot light codes {R,Y,G}
   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_OFF = 3'b000;

   // Mirrors the system-wide time limits
   localparam int MIN_TIME = 0;
   localparam int MAX_TIME = 99;

   typedef struct packed {
      time_t g;
      time_t y;
      time_t r;
   } times_t;

   // Sum is formed at 8 bits so a 7-bit overflow can never alias a legal red time
   function automatic logic cfg_legal(input times_t t);
      logic [7:0] sum;
      sum = {1'b0, t.g} + {1'b0, t.y};
      return (t.g > time_t'(MIN_TIME)) && (t.y > time_t'(MIN_TIME)) &&
             (sum == {1'b0, t.r}) && (t.r <= time_t'(MAX_TIME));
   endfunction

endpackage

`default_nettype wire

// File: rtl/tl_lane_counter.sv
// +----------------------------------------------------------------------+
// | Module   : tl_lane_counter                                           |
// | Purpose  : Per-lane seconds display: synchronous load with priority  |
// |            over a gated decrement, plus a "showing 1" flag.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tl_lane_counter
   import tl_pkg::*;
#(
   parameter time_t RESET_VAL = 7'd30
)(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  time_t load_val,
   input  logic  dec,
   output time_t value,
   output logic  is_one
);

   time_t value_q, value_d;

   // Load wins over decrement; the controller never decrements from 1
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (dec) begin
         value_d = value_q - 7'd1;
      end
   end

   // Display register
   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= RESET_VAL;
      end else begin
         value_q <= value_d;
      end
   end

   assign value  = value_q;
   assign is_one = (value_q == 7'd1);

endmodule

`default_nettype wire

// File: rtl/traffic_phase_controller.sv
// +----------------------------------------------------------------------+
// | Module   : traffic_phase_controller                                  |
// | Purpose  : Normal-mode two-lane phase sequencer with shadowed,       |
// |            handshake-loaded green/yellow/red times applied only at   |
// |            a cycle boundary.                                         |
// | Options  : TLC_FLASH_EN - flashing yellow, blank displays in IDLE    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module traffic_phase_controller
   import tl_pkg::*;
#(
   parameter int DEF_GREEN  = 25,
   parameter int DEF_YELLOW = 5,
   parameter int DEF_RED    = 30
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       run,
   input  logic       cfg_valid,
   input  logic [6:0] cfg_green,
   input  logic [6:0] cfg_yellow,
   input  logic [6:0] cfg_red,
   output logic       cfg_ready,
   output logic       cfg_err,
   output logic [2:0] light1,
   output logic [2:0] light2,
   output logic [6:0] timeLane1,
   output logic [6:0] timeLane2,
   output logic [2:0] phase
);

   localparam times_t DEF_TIMES = '{g: time_t'(DEF_GREEN),
                                    y: time_t'(DEF_YELLOW),
                                    r: time_t'(DEF_RED)};

   phase_e     state_q, state_d;
   times_t     active_q, active_d;
   times_t     shadow_q, shadow_d;
   logic       pend_q, pend_d;
   logic       cfg_ready_q, cfg_ready_d;
   logic       cfg_err_q, cfg_err_d;
   logic [2:0] light1_q, light1_d;
   logic [2:0] light2_q, light2_d;

   logic       cfg_accept;
   logic       boundary;
   logic       load1, load2, dec;
   time_t      load1_val, load2_val;
   time_t      cnt1, cnt2;
   logic       one1, one2;
   logic [2:0] idle_light;
   time_t      idle_time;
   times_t     proposal;

   assign proposal = '{g: cfg_green, y: cfg_yellow, r: cfg_red};

   // Config handshake: sample only when no pulse was issued last cycle
   always_comb begin
      shadow_d    = shadow_q;
      cfg_ready_d = 1'b0;
      cfg_err_d   = 1'b0;
      cfg_accept  = 1'b0;
      if (cfg_valid && !cfg_ready_q && !cfg_err_q) begin
         if (cfg_legal(proposal)) begin
            shadow_d    = proposal;
            cfg_ready_d = 1'b1;
            cfg_accept  = 1'b1;
         end else begin
            cfg_err_d   = 1'b1;
         end
      end
   end

`ifdef TLC_FLASH_EN
   logic flash_q, flash_d;

   // Flash phase: forced on while sequencing so IDLE entry starts lit
   always_comb begin
      flash_d = flash_q;
      if (state_q != IDLE) begin
         flash_d = 1'b1;
      end else if (tick) begin
         flash_d = ~flash_q;
      end
   end

   // Flash phase register
   always_ff @(posedge clk) begin
      if (reset) begin
         flash_q <= 1'b1;
      end else begin
         flash_q <= flash_d;
      end
   end

   assign idle_light = flash_d ? L_YEL : L_OFF;
   assign idle_time  = '0;
`else
   assign idle_light = L_RED;
   assign idle_time  = active_q.r;
`endif

   // Phase sequencing, boundary time swap, display loads and light decode
   always_comb begin
      state_d   = state_q;
      boundary  = 1'b0;
      load1     = 1'b0;
      load2     = 1'b0;
      load1_val = '0;
      load2_val = '0;
      dec       = 1'b0;
      light1_d  = L_RED;
      light2_d  = L_RED;

      if (!run) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = G1R2;
               boundary = 1'b1;
            end
            G1R2: if (tick && one1) state_d = Y1R2;
            Y1R2: if (tick && one1) state_d = R1G2;
            R1G2: if (tick && one2) state_d = R1Y2;
            R1Y2: if (tick && one2) begin
               state_d  = G1R2;
               boundary = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end

      // A proposal accepted this same cycle lands in pend, not in active
      active_d = (boundary && pend_q) ? shadow_q : active_q;
      pend_d   = cfg_accept | (pend_q & ~boundary);

      if (state_d == IDLE) begin
         load1     = 1'b1;
         load2     = 1'b1;
         load1_val = idle_time;
         load2_val = idle_time;
      end else if (state_d != state_q) begin
         load1 = 1'b1;
         load2 = 1'b1;
         case (state_d)
            G1R2:    begin load1_val = active_d.g; load2_val = active_d.r; end
            R1G2:    begin load1_val = active_d.r; load2_val = active_d.g; end
            default: begin load1_val = active_d.y; load2_val = active_d.y; end
         endcase
      end else begin
         dec = tick;
      end

      case (state_d)
         IDLE:    begin light1_d = idle_light; light2_d = idle_light; end
         G1R2:    begin light1_d = L_GRN;      light2_d = L_RED;      end
         Y1R2:    begin light1_d = L_YEL;      light2_d = L_RED;      end
         R1G2:    begin light1_d = L_RED;      light2_d = L_GRN;      end
         R1Y2:    begin light1_d = L_RED;      light2_d = L_YEL;      end
         default: begin light1_d = L_RED;      light2_d = L_RED;      end
      endcase
   end

   // Controller state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         active_q    <= DEF_TIMES;
         shadow_q    <= DEF_TIMES;
         pend_q      <= 1'b0;
         cfg_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         light1_q    <= L_RED;
         light2_q    <= L_RED;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         shadow_q    <= shadow_d;
         pend_q      <= pend_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
         light1_q    <= light1_d;
         light2_q    <= light2_d;
      end
   end

   tl_lane_counter #(.RESET_VAL(time_t'(DEF_RED))) u_lane1 (
      .clk      (clk),
      .reset    (reset),
      .load     (load1),
      .load_val (load1_val),
      .dec      (dec),
      .value    (cnt1),
      .is_one   (one1)
   );

   tl_lane_counter #(.RESET_VAL(time_t'(DEF_RED))) u_lane2 (
      .clk      (clk),
      .reset    (reset),
      .load     (load2),
      .load_val (load2_val),
      .dec      (dec),
      .value    (cnt2),
      .is_one   (one2)
   );

   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;
   assign light1    = light1_q;
   assign light2    = light2_q;
   assign timeLane1 = cnt1;
   assign timeLane2 = cnt2;
   assign phase     = state_q;

endmodule

`default_nettype wire
